// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display bank: register map, CTRL bit positions
// and the active-high hex glyph table (bit 0 = segment a ... bit 6 = segment g).
package hex_display_pkg;

    localparam logic [3:0] ADDR_CTRL         = 4'h0;
    localparam logic [3:0] ADDR_BLINK_MASK   = 4'h1;
    localparam logic [3:0] ADDR_BLINK_PERIOD = 4'h2;
    localparam logic [3:0] ADDR_DIGIT_BASE   = 4'h8;

    localparam int CTRL_DECODE = 0;
    localparam int CTRL_BLANK  = 1;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to 7-segment glyph decoder; output is active-high
// (1 = segment lit), polarity is applied later in the display bank.
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = hex_glyph(nibble);

endmodule

// File: rtl/hex_display_bank.sv
// Avalon-MM controlled bank of NUM_DIGITS 7-segment displays with hex decode,
// blanking and optional per-digit blinking (enabled by HEX_DISPLAY_BANK_BLINK_EN).
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int PRESCALE       = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port
);

    localparam logic [6:0]              SEG_UNLIT  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [7*NUM_DIGITS-1:0] PORT_UNLIT = {NUM_DIGITS{SEG_UNLIT}};

    // Bus handshake: no waitrequest, so a write is taken on every rising edge
    // with chipselect=1 and write_n=0; readdata is a pure function of address.
    logic                    wr_en;
    logic [1:0]              ctrl;
    logic [6:0]              digit [NUM_DIGITS];
    logic [6:0]              glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blink_off;
    logic [7*NUM_DIGITS-1:0] seg_next;
    logic [7*NUM_DIGITS-1:0] seg_pipe;
    logic                    unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit[i] <= '0;
            end
        end else if (wr_en) begin
            if (address == ADDR_CTRL) begin
                ctrl <= writedata[1:0];
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == ADDR_DIGIT_BASE + 4'(i)) begin
                    digit[i] <= writedata[6:0];
                end
            end
        end
    end

`ifdef HEX_DISPLAY_BANK_BLINK_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [NUM_DIGITS-1:0] blink_mask;
    logic [15:0]           blink_period;
    logic [15:0]           phase_cnt;
    logic [PS_W-1:0]       prescale_cnt;
    logic                  blink_phase;
    logic                  tick;
    logic                  period_wr;

    assign tick      = (prescale_cnt == PS_W'(PRESCALE - 1));
    assign period_wr = wr_en && (address == ADDR_BLINK_PERIOD);
    assign blink_off = blink_phase ? blink_mask : '0;

    // A period write restarts the blink cycle and takes priority over a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask   <= '0;
            blink_period <= '0;
            phase_cnt    <= '0;
            prescale_cnt <= '0;
            blink_phase  <= 1'b0;
        end else begin
            prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
            if (wr_en && (address == ADDR_BLINK_MASK)) begin
                blink_mask <= writedata[NUM_DIGITS-1:0];
            end
            if (period_wr) begin
                blink_period <= writedata[15:0];
                phase_cnt    <= '0;
                blink_phase  <= 1'b0;
            end else if (blink_period == 16'd0) begin
                phase_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (tick) begin
                if (phase_cnt == blink_period - 16'd1) begin
                    phase_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    phase_cnt <= phase_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign blink_off = '0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:         readdata[1:0] = ctrl;
`ifdef HEX_DISPLAY_BANK_BLINK_EN
            ADDR_BLINK_MASK:   readdata[NUM_DIGITS-1:0] = blink_mask;
            ADDR_BLINK_PERIOD: readdata[15:0] = blink_period;
`else
            ADDR_BLINK_MASK,
            ADDR_BLINK_PERIOD: readdata = '0;
`endif
            default:           readdata = '0;
        endcase
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == ADDR_DIGIT_BASE + 4'(i)) begin
                readdata[6:0] = digit[i];
            end
        end
    end

    // Blank overrides everything; polarity inversion is the very last stage.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [6:0] lit;

        hex_seg_decode u_decode (
            .nibble (digit[g][3:0]),
            .glyph  (glyph[g])
        );

        assign lit = (ctrl[CTRL_BLANK] || blink_off[g]) ? 7'h00 :
                     (ctrl[CTRL_DECODE] ? glyph[g] : digit[g]);
        assign seg_next[7*g +: 7] = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_pipe <= PORT_UNLIT;
            out_port <= PORT_UNLIT;
        end else begin
            seg_pipe <= seg_next;
            out_port <= seg_pipe;
        end
    end

endmodule

// File: tb/tb_hex_display_bank.sv
// Randomized scoreboard bench for hex_display_bank: a behavioural register and
// blink model predicts out_port and readdata; a monitor compares them.
`timescale 1ns/1ps
module tb_hex_display_bank;

    localparam int NUM_DIGITS = 6;
    localparam int PRESCALE   = 4;
    localparam int W          = 7 * NUM_DIGITS;

    localparam logic [6:0] GLYPH_REF [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    hex_display_bank #(
        .NUM_DIGITS     (NUM_DIGITS),
        .PRESCALE       (PRESCALE),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0]            m_ctrl;
    logic [6:0]            m_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] m_mask;
    logic [15:0]           m_period;
    int                    m_edges;
    int                    m_ticks;
    bit                    m_started = 1'b0;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   rd_q[$];
    bit            rd_req = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    function automatic bit m_phase();
`ifdef HEX_DISPLAY_BANK_BLINK_EN
        if (m_period == 16'd0) return 1'b0;
        return ((m_ticks / int'(m_period)) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] m_segments();
        logic [W-1:0] s;
        logic [6:0]   lit;
        s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (m_ctrl[1])                    lit = 7'h00;
            else if (m_mask[i] && m_phase())  lit = 7'h00;
            else if (m_ctrl[0])               lit = GLYPH_REF[m_digit[i][3:0]];
            else                              lit = m_digit[i];
            s[7*i +: 7] = ~lit;
        end
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0) return {30'd0, m_ctrl};
        if (ai >= 8 && ai - 8 < NUM_DIGITS) return {25'd0, m_digit[ai-8]};
`ifdef HEX_DISPLAY_BANK_BLINK_EN
        if (ai == 1) return 32'(m_mask);
        if (ai == 2) return {16'd0, m_period};
`endif
        return 32'd0;
    endfunction

    task automatic m_clear();
        m_ctrl   = '0;
        m_mask   = '0;
        m_period = '0;
        m_edges  = 0;
        m_ticks  = 0;
        for (int i = 0; i < NUM_DIGITS; i++) m_digit[i] = '0;
    endtask

    task automatic m_write(input logic [3:0] a, input logic [31:0] d);
        int ai;
        ai = int'(a);
        if (ai == 0) m_ctrl = d[1:0];
        else if (ai >= 8 && ai - 8 < NUM_DIGITS) m_digit[ai-8] = d[6:0];
`ifdef HEX_DISPLAY_BANK_BLINK_EN
        else if (ai == 1) m_mask = d[NUM_DIGITS-1:0];
        else if (ai == 2) begin
            m_period = d[15:0];
            m_ticks  = 0;
        end
`endif
    endtask

    // Model advances on every edge and queues the segment image it implies.
    initial begin
        forever begin
            bit tick;
            bit pw;
            @(posedge clk);
            if (reset) begin
                m_clear();
                m_started = 1'b1;
                exp_q.delete();
                exp_q.push_back({W{1'b1}});
                exp_q.push_back({W{1'b1}});
                exp_q.push_back(m_segments());
            end else if (m_started) begin
                tick = (m_edges % PRESCALE) == PRESCALE - 1;
                pw   = chipselect && !write_n && (address == 4'h2);
                if (chipselect && !write_n) m_write(address, writedata);
`ifdef HEX_DISPLAY_BANK_BLINK_EN
                if (!pw && m_period != 16'd0 && tick) m_ticks++;
`endif
                m_edges++;
                exp_q.push_back(m_segments());
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    initial begin
        forever begin
            logic [W-1:0] e;
            logic [31:0]  r;
            @(negedge clk);
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                check("out_port", 64'(out_port), 64'(e));
            end
            if (rd_req) begin
                if (rd_q.size() == 0) begin
                    check("rd_queue_empty", 64'd1, 64'd0);
                end else begin
                    r = rd_q.pop_front();
                    check($sformatf("readdata@%h", address), 64'(readdata), 64'(r));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        @(posedge clk); #2;
        chipselect = 1'b0; write_n = 1'b1; rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_idle();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; rd_req = 1'b0;
    endtask

    task automatic bus_write_nocs(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        address = a; writedata = d; chipselect = 1'b0; write_n = 1'b0; rd_req = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a);
        @(posedge clk); #2;
        address = a; chipselect = 1'b1; write_n = 1'b1;
        rd_q.push_back(m_read(a));
        rd_req = 1'b1;
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #2;
        reset = 1'b1; address = 4'h8; writedata = 32'h5;
        chipselect = 1'b1; write_n = 1'b0; rd_req = 1'b0;
        repeat (cycles - 1) @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 16; i++) bus_read(4'(i));

        // decode of 0xA on digit 0
        bus_write(4'h0, 32'h1);
        bus_write(4'h8, 32'hA);
        idle(4);
        bus_read(4'h8);

        // raw segments then blank
        bus_write(4'h0, 32'h0);
        bus_write(4'h9, 32'h7F);
        idle(4);
        bus_write(4'h0, 32'h2);
        idle(4);
        bus_write(4'h0, 32'h0);

        // unmapped addresses
        bus_write(4'hE, 32'hF);
        bus_write(4'(8 + NUM_DIGITS), 32'hF);
        bus_write(4'h3, 32'hFFFF_FFFF);
        bus_write(4'hF, 32'hFFFF_FFFF);
        idle(3);
        bus_read(4'hE);
        bus_read(4'h3);
        bus_read(4'hF);
        bus_read(4'(8 + NUM_DIGITS));

`ifdef HEX_DISPLAY_BANK_BLINK_EN
        bus_write(4'h0, 32'h1);
        for (int i = 0; i < NUM_DIGITS; i++) bus_write(4'(8 + i), 32'(i + 1));
        bus_write(4'h1, 32'h1);
        bus_write(4'h2, 32'h2);
        bus_read(4'h1);
        bus_read(4'h2);
        idle(40);
        // period write landing on a tick edge
        while (((m_edges + 1) % PRESCALE) != PRESCALE - 1) drive_idle();
        bus_write(4'h2, 32'h3);
        idle(30);
        bus_write(4'h2, 32'h1);
        idle(20);
        bus_write(4'h2, 32'h0);
        idle(410);
`else
        bus_write(4'h1, 32'h3F);
        bus_write(4'h2, 32'h5);
        idle(4);
        bus_read(4'h1);
        bus_read(4'h2);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            if (a == 4'h2) d = 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: bus_write(a, d);
                5:             bus_write_nocs(a, d);
                6, 7:          bus_read(a);
                8:             drive_idle();
                default: begin
                    if ($urandom_range(0, 19) == 0) apply_reset($urandom_range(1, 3));
                    else drive_idle();
                end
            endcase
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
